// File: rtl/robot_predict_grid_mem.sv
// Obstacle-robot occupancy predictor. For each robot it walks the predicted
// positions k = 0..kMax along that robot's velocity and sets the matching cell
// bit in an external bitmap RAM by read-modify-write. The bitmap can first be
// wiped (mode 0) or accumulated onto (mode 1). Points that fall off the grid
// are counted and skipped.
module robot_predict_grid_mem #(
  parameter int ROBOT_NUM = 4,
  parameter int COORD_W   = 16,
  parameter int FRAC_BITS = 4,
  parameter int GX_BITS   = 8,
  parameter int GY_BITS   = 8,
  parameter int WORD_W    = 32,
  parameter int STEP_MAX  = 15
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic                                       start,
  input  logic                                       mode,
  input  logic [7:0]                                 step,
  input  logic [2*COORD_W*ROBOT_NUM-1:0]             robotPos,
  input  logic [2*COORD_W*ROBOT_NUM-1:0]             robotVel,
  output logic                                       busy,
  output logic                                       done,
  output logic [GX_BITS+GY_BITS-$clog2(WORD_W)-1:0]  memAddr,
  output logic                                       memRdEn,
  input  logic [WORD_W-1:0]                          memRdData,
  output logic                                       memWrEn,
  output logic [WORD_W-1:0]                          memWrData,
  output logic [15:0]                                markCount,
  output logic [15:0]                                oobCount
);

  localparam int WB     = $clog2(WORD_W);
  localparam int IDX_W  = GX_BITS + GY_BITS;
  localparam int ADDR_W = IDX_W - WB;
  localparam int WORDS  = 1 << ADDR_W;
  // Five guard bits cover 15 velocity additions on top of the start position.
  localparam int ACC_W  = COORD_W + 5;
  localparam int R_W    = (ROBOT_NUM > 1) ? $clog2(ROBOT_NUM) : 1;

  localparam logic [7:0]        STEP_CAP  = 8'(STEP_MAX);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam logic [R_W-1:0]    LAST_ROB  = R_W'(ROBOT_NUM - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    POINT = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Run context captured at start; data only, so no reset.
  logic signed [COORD_W-1:0] pos_x_p0 [ROBOT_NUM];
  logic signed [COORD_W-1:0] pos_y_p0 [ROBOT_NUM];
  logic signed [COORD_W-1:0] vel_x_p0 [ROBOT_NUM];
  logic signed [COORD_W-1:0] vel_y_p0 [ROBOT_NUM];
  logic signed [ACC_W-1:0]   acc_x_p0;
  logic signed [ACC_W-1:0]   acc_y_p0;

  logic [R_W-1:0]    r_idx;
  logic [R_W-1:0]    r_nxt;
  logic [7:0]        k_idx;
  logic [7:0]        k_max;
  logic [ADDR_W-1:0] clr_addr;
  logic [15:0]       mark_cnt;
  logic [15:0]       oob_cnt;
  logic              done_q;

  logic signed [ACC_W-1:0] cell_x;
  logic signed [ACC_W-1:0] cell_y;
  logic                    in_bounds;
  logic [IDX_W-1:0]        cell_idx;
  logic [ADDR_W-1:0]       word_addr;
  logic [WORD_W-1:0]       bit_mask;
  logic                    last_k;
  logic                    last_r;
  logic                    advance;

  function automatic logic signed [ACC_W-1:0] to_acc(input logic signed [COORD_W-1:0] v);
    to_acc = {{(ACC_W-COORD_W){v[COORD_W-1]}}, v};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Floor to cell index; off-grid whenever any bit above the grid width is set
  // (this also catches negative cells through the sign bit).
  assign cell_x    = acc_x_p0 >>> FRAC_BITS;
  assign cell_y    = acc_y_p0 >>> FRAC_BITS;
  assign in_bounds = (cell_x[ACC_W-1:GX_BITS] == '0) && (cell_y[ACC_W-1:GY_BITS] == '0);
  assign cell_idx  = {cell_y[GY_BITS-1:0], cell_x[GX_BITS-1:0]};
  assign word_addr = cell_idx[IDX_W-1:WB];
  assign bit_mask  = WORD_W'(1) << cell_idx[WB-1:0];

  assign last_k  = (k_idx == k_max);
  assign last_r  = (r_idx == LAST_ROB);
  assign r_nxt   = r_idx + 1'b1;
  assign advance = ((state == POINT) && !in_bounds) || (state == WRITE);

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign markCount = mark_cnt;
  assign oobCount  = oob_cnt;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and memory strobes.
  always_comb begin
    state_nxt = state;
    memRdEn   = 1'b0;
    memWrEn   = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = mode ? POINT : CLEAR;
      end
      CLEAR: begin
        memWrEn = 1'b1;
        memAddr = clr_addr;
        if (clr_addr == LAST_WORD) state_nxt = POINT;
      end
      POINT: begin
        if (in_bounds) begin
          memRdEn   = 1'b1;
          memAddr   = word_addr;
          state_nxt = WRITE;
        end else if (last_k && last_r) begin
          state_nxt = FIN;
        end
      end
      WRITE: begin
        memWrEn   = 1'b1;
        memAddr   = word_addr;
        memWrData = memRdData | bit_mask;
        state_nxt = (last_k && last_r) ? FIN : POINT;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loop indices, clear address, counters and the done pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx    <= '0;
      k_idx    <= '0;
      k_max    <= '0;
      clr_addr <= '0;
      mark_cnt <= '0;
      oob_cnt  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == FIN);
      if ((state == IDLE) && start) begin
        r_idx    <= '0;
        k_idx    <= '0;
        k_max    <= (step > STEP_CAP) ? STEP_CAP : step;
        clr_addr <= '0;
        mark_cnt <= '0;
        oob_cnt  <= '0;
      end
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if ((state == POINT) && !in_bounds) oob_cnt <= sat_inc(oob_cnt);
      if (state == WRITE) mark_cnt <= sat_inc(mark_cnt);
      if (advance) begin
        if (!last_k) begin
          k_idx <= k_idx + 8'd1;
        end else if (!last_r) begin
          r_idx <= r_nxt;
          k_idx <= '0;
        end
      end
    end
  end

  // Capture robot context and step the position accumulator.
  always_ff @(posedge CLK) begin
    if ((state == IDLE) && start) begin
      for (int i = 0; i < ROBOT_NUM; i++) begin
        pos_x_p0[i] <= robotPos[2*COORD_W*i +: COORD_W];
        pos_y_p0[i] <= robotPos[2*COORD_W*i+COORD_W +: COORD_W];
        vel_x_p0[i] <= robotVel[2*COORD_W*i +: COORD_W];
        vel_y_p0[i] <= robotVel[2*COORD_W*i+COORD_W +: COORD_W];
      end
      acc_x_p0 <= to_acc(robotPos[0 +: COORD_W]);
      acc_y_p0 <= to_acc(robotPos[COORD_W +: COORD_W]);
    end else if (advance) begin
      if (!last_k) begin
        acc_x_p0 <= acc_x_p0 + to_acc(vel_x_p0[r_idx]);
        acc_y_p0 <= acc_y_p0 + to_acc(vel_y_p0[r_idx]);
      end else if (!last_r) begin
        acc_x_p0 <= to_acc(pos_x_p0[r_nxt]);
        acc_y_p0 <= to_acc(pos_y_p0[r_nxt]);
      end
    end
  end

endmodule

// File: tb/tb_robot_predict_grid_mem.sv
// Directed bench for robot_predict_grid_mem with a behavioural bitmap RAM and
// a scoreboard of expected RAM writes built from a closed-form position model.
module tb_robot_predict_grid_mem;

  localparam int RN = 2;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [7:0]    step = 8'd0;
  logic [63:0]   robotPos = '0;
  logic [63:0]   robotVel = '0;
  logic          busy, done;
  logic [2:0]    memAddr;
  logic          memRdEn, memWrEn;
  logic [31:0]   memRdData, memWrData;
  logic [15:0]   markCount, oobCount;

  robot_predict_grid_mem #(
    .ROBOT_NUM(RN), .COORD_W(CW), .FRAC_BITS(4), .GX_BITS(4), .GY_BITS(4),
    .WORD_W(32), .STEP_MAX(15)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode), .step(step),
    .robotPos(robotPos), .robotVel(robotVel), .busy(busy), .done(done),
    .memAddr(memAddr), .memRdEn(memRdEn), .memRdData(memRdData),
    .memWrEn(memWrEn), .memWrData(memWrData),
    .markCount(markCount), .oobCount(oobCount)
  );

  always #5 CLK = ~CLK;

  // Bitmap RAM: one-cycle read latency, bench preload port takes priority.
  logic [31:0] mem [8];
  logic [31:0] rd_q;
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  assign memRdData = rd_q;

  // RAM model.
  always @(posedge CLK) begin
    if (pre_we)       mem[pre_addr] <= pre_data;
    else if (memWrEn) mem[memAddr] <= memWrData;
    if (memRdEn) rd_q <= mem[memAddr];
  end

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q [$];
  logic [31:0] shadow [8];
  int          exp_mark, exp_oob, exp_lat;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pk(input logic [15:0] x0, input logic [15:0] y0,
                                     input logic [15:0] x1, input logic [15:0] y1);
    return {y1, x1, y0, x0};
  endfunction

  // Reference: position = pos + k*vel, evaluated directly per point.
  task automatic model(input logic md, input logic [7:0] st,
                       input logic [63:0] pos, input logic [63:0] vel);
    int  kmax, px, py, vx, vy, x, y, cx, cy, idx, w;
    wr_t e;
    kmax = (st > 8'd15) ? 15 : int'(st);
    exp_mark = 0;
    exp_oob  = 0;
    if (!md) begin
      for (int a = 0; a < 8; a++) begin
        shadow[a] = '0;
        e.addr = a[2:0];
        e.data = '0;
        exp_q.push_back(e);
      end
    end
    for (int r = 0; r < RN; r++) begin
      px = int'($signed(pos[32*r +: 16]));
      py = int'($signed(pos[32*r+16 +: 16]));
      vx = int'($signed(vel[32*r +: 16]));
      vy = int'($signed(vel[32*r+16 +: 16]));
      for (int k = 0; k <= kmax; k++) begin
        x  = px + k * vx;
        y  = py + k * vy;
        cx = x >>> 4;
        cy = y >>> 4;
        if (cx >= 0 && cx < 16 && cy >= 0 && cy < 16) begin
          idx = cy * 16 + cx;
          w   = idx / 32;
          shadow[w] = shadow[w] | (32'd1 << (idx % 32));
          e.addr = w[2:0];
          e.data = shadow[w];
          exp_q.push_back(e);
          exp_mark++;
        end else begin
          exp_oob++;
        end
      end
    end
    exp_lat = 1 + (md ? 0 : 8) + 2 * exp_mark + exp_oob;
  endtask

  task automatic run(input string tag, input logic md, input logic [7:0] st,
                     input logic [63:0] pos, input logic [63:0] vel, input bit disturb);
    int  cyc, lat, dones, extra, ovl;
    wr_t e;
    model(md, st, pos, vel);
    @(negedge CLK);
    start = 1'b1; mode = md; step = st; robotPos = pos; robotVel = vel;
    @(posedge CLK);
    #1 start = 1'b0;
    cyc = 0; lat = -1; dones = 0; extra = 0; ovl = 0;
    while (cyc < 300) begin
      @(negedge CLK);
      if (memRdEn && memWrEn) ovl++;
      if (memWrEn) begin
        if (exp_q.size() == 0) extra++;
        else begin
          e = exp_q.pop_front();
          chk({tag, "_wr"}, {29'd0, memAddr, memWrData}, {29'd0, e.addr, e.data});
        end
      end
      if (disturb && cyc == 5) begin
        start = 1'b1; robotPos = ~pos; robotVel = ~vel; mode = ~md;
      end
      if (disturb && cyc == 6) start = 1'b0;
      if (done) begin
        lat = cyc;
        dones++;
        chk({tag, "_busy_at_done"}, busy, 0);
        break;
      end
      @(posedge CLK);
      cyc++;
    end
    repeat (3) begin
      @(negedge CLK);
      if (done) dones++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_markCount"}, markCount, exp_mark);
    chk({tag, "_oobCount"}, oobCount, exp_oob);
    chk({tag, "_missing_writes"}, exp_q.size(), 0);
    chk({tag, "_extra_writes"}, extra, 0);
    chk({tag, "_rd_wr_overlap"}, ovl, 0);
    for (int w = 0; w < 8; w++) chk({tag, "_word", $sformatf("%0d", w)}, mem[w], shadow[w]);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_memRdEn", memRdEn, 0);
    chk("rst_memWrEn", memWrEn, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memWrData", memWrData, 0);
    chk("rst_markCount", markCount, 0);
    chk("rst_oobCount", oobCount, 0);
    @(negedge CLK) RST = 1'b0;

    // Basic mark: cells 35,36,37 and cell 0.
    run("basic", 1'b0, 8'd2, pk(16'h0030, 16'h0020, 16'h0000, 16'h0000),
        pk(16'h0010, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    chk("basic_word1_const", mem[1], 32'h0000_0038);
    chk("basic_word0_const", mem[0], 32'h0000_0001);
    chk("basic_mark_const", markCount, 6);

    // Right/left edges with floor and out-of-grid rejection.
    run("bounds", 1'b0, 8'd2, pk(16'h00F0, 16'h0000, 16'h0000, 16'h0000),
        pk(16'h0010, 16'h0000, 16'hFFF0, 16'h0000), 1'b0);
    chk("bounds_word0_const", mem[0], 32'h0000_8001);
    chk("bounds_oob_const", oobCount, 4);

    run("floor", 1'b0, 8'd0, pk(16'h001F, 16'h0000, 16'hFFFF, 16'h0000), '0, 1'b0);
    chk("floor_word0_const", mem[0], 32'h0000_0002);

    // Accumulate onto a preloaded word, no clearing pass.
    @(negedge CLK);
    pre_we = 1'b1; pre_addr = 3'd2; pre_data = 32'hFFFF_0000;
    @(posedge CLK);
    #1 pre_we = 1'b0;
    shadow[2] = 32'hFFFF_0000;
    run("accum", 1'b1, 8'd0, pk(16'h0000, 16'h0040, 16'h0000, 16'h0040), '0, 1'b0);
    chk("accum_word2_const", mem[2], 32'hFFFF_0001);

    // Horizon clamp to 15.
    run("clamp", 1'b0, 8'd200, pk(16'h0000, 16'h0000, 16'h0000, 16'h0080),
        pk(16'h0010, 16'h0000, 16'h0020, 16'h0000), 1'b0);
    chk("clamp_total_points", markCount + oobCount, 32);

    // start and input changes mid-run must not disturb the run.
    run("busy_start", 1'b0, 8'd2, pk(16'h0030, 16'h0020, 16'h0000, 16'h0000),
        pk(16'h0010, 16'h0000, 16'h0000, 16'h0000), 1'b1);

    // Reset in the middle of the clearing pass.
    @(negedge CLK);
    start = 1'b1; mode = 1'b0; step = 8'd3;
    robotPos = pk(16'h0050, 16'h0050, 16'h0010, 16'h0010);
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_memWrEn", memWrEn, 0);
    chk("midrst_done", done, 0);
    chk("midrst_markCount", markCount, 0);
    chk("midrst_oobCount", oobCount, 0);
    @(negedge CLK) RST = 1'b0;

    run("after_rst", 1'b0, 8'd2, pk(16'h0030, 16'h0020, 16'h0000, 16'h0000),
        pk(16'h0010, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    chk("after_rst_word1_const", mem[1], 32'h0000_0038);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/robot_predict_grid_mem.md
Name: robot_predict_grid_mem

Overview:
- Parametrised successor of the obstacle-robot occupancy predictor.
- For ROBOT_NUM obstacle robots it extrapolates position over 0..step future steps, using per-robot velocity.
- Each predicted cell is marked in an external bitmap RAM by read-modify-write; there is no flat gridWidth-bit output bus.
- Adds clear/accumulate mode, out-of-bounds rejection and mark/OOB counters. Sits between the stepper-position source and the PRM collision checker, which reads the bitmap.

Parameters:
ROBOT_NUM, 4, number of obstacle robots
COORD_W, 16, signed fixed-point coordinate width (x and y each)
FRAC_BITS, 4, fractional bits per coordinate (1 cell = 2^FRAC_BITS)
GX_BITS, 8, log2 grid cells in x
GY_BITS, 8, log2 grid cells in y
WORD_W, 32, bitmap RAM word width (power of 2, ≤ 2^GX_BITS)
STEP_MAX, 15, maximum prediction horizon

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
start  in  1  begin a prediction run (accepted only in IDLE)
mode  in  1  0 = clear bitmap then mark, 1 = accumulate onto existing bitmap
step  in  8  horizon; steps k=0..min(step,STEP_MAX)
robotPos  in  2*COORD_W*ROBOT_NUM  per robot {y,x}, robot r at bits [2*COORD_W*(r+1)-1 : 2*COORD_W*r]
robotVel  in  2*COORD_W*ROBOT_NUM  per robot {y,x} displacement per step, same packing
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
memAddr  out  GX_BITS+GY_BITS-log2(WORD_W)  bitmap word address
memRdEn  out  1  read request; memRdData valid the following cycle
memRdData  in  WORD_W  read data
memWrEn  out  1  write strobe
memWrData  out  WORD_W  write data
markCount  out  16  cells marked in last run (saturating)
oobCount  out  16  predicted points rejected as out of grid (saturating)

Behaviour:
- Reset (RST high at a rising edge): state IDLE. busy, done, memRdEn, memWrEn, memAddr, memWrData, markCount and oobCount all 0. Takes effect at that edge even mid-run; bitmap contents are not repaired.
- IDLE: on start=1, latch robotPos, robotVel, mode, and kMax=min(step,STEP_MAX). Clear both counters, r=0, k=0, acc=pos[0]. busy=1 from the next cycle. Next state is CLEAR if mode=0, else POINT.
- start while busy is ignored. Input changes during a run have no effect.
- CLEAR: writes 0 to word addresses 0..WORDS-1, one per cycle, with WORDS=2^(GX_BITS+GY_BITS)/WORD_W. Then goes to POINT.
- Accumulator: acc is per-axis signed, COORD_W+5 bits, so it cannot overflow for STEP_MAX≤15.
- Predicted cell: cx = acc.x >>> FRAC_BITS (arithmetic shift, floor), cy likewise.
- POINT, out-of-bounds case (cx<0, cx≥2^GX_BITS, cy<0 or cy≥2^GY_BITS): increment oobCount, advance. Takes 1 cycle; no memory access.
- POINT, in-bounds case: idx={cy,cx}; memAddr=idx>>log2(WORD_W), memRdEn=1; go to WRITE.
- WRITE: memWrEn=1, same memAddr, memWrData = memRdData | (1 << idx[log2(WORD_W)-1:0]). Increment markCount (counted even if the bit was already set). Advance; next state is POINT. Each in-bounds point costs 2 cycles.
- Advance:
  - if k<kMax: k++, acc+=vel[r];
  - else if r<ROBOT_NUM-1: r++, k=0, acc=pos[r];
  - else go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE. Counters hold until the next accepted start.
- Strobes: memRdEn and memWrEn are never high together and are only high in the states named above.
- Latency: done is high N cycles after the start-sampling edge, with N = 1 + (mode=0 ? WORDS : 0) + 2·inBounds + outOfBounds.

Test Plan:
Bench parameters: ROBOT_NUM=2, GX=GY=4, WORD_W=32, FRAC=4, WORDS=8.
1. Basic mark. Stimulus: mode0, step=2; r0 pos(x=0x0030,y=0x0020) vel(0x0010,0); r1 pos 0 vel 0. Required: cells 35,36,37 set, so word1=0x00000038 and word0=0x00000001. markCount=6, oobCount=0. done 21 cycles after start.
2. Bounds and floor. Stimulus: r0 x=0x00F0 vel +0x0010; r1 x=0 vel −0x0010; step=2. Required: only cells 15 and 0 set, markCount=2, oobCount=4. Separately, x=0x001F maps to cell 1 and x=−0x0001 is OOB.
3. Accumulate. Stimulus: preload word2=0xFFFF0000; mode1, r0 at cell 64 (y=4,x=0), step=0, r1 at cell 64. Required: word2=0xFFFF0001, no CLEAR writes, markCount=2, done after 5 cycles.
4. Clamp. Stimulus: step=200. Required: 16 points per robot; markCount+oobCount=32.
5. Start while busy. Stimulus: pulse start and change robotPos mid-run. Required: results identical to an undisturbed run; exactly one done pulse.
6. Reset mid-CLEAR. Stimulus: RST at cycle 4. Required: next cycle busy=0, memWrEn=0, counters 0; a subsequent start completes normally.
